// File: rtl/core_mmio_lsu_if.sv
// core_mmio_lsu_if: request/response MMIO bus between the load/store unit and the uncached fabric
interface core_mmio_lsu_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [7:0]      be;
    logic            rsp_valid;
    logic [XLEN-1:0] rdata;
    modport master (output req_valid, we, addr, wdata, be, input req_ready, rsp_valid, rdata);
    modport slave  (input req_valid, we, addr, wdata, be, output req_ready, rsp_valid, rdata);
endinterface

// File: rtl/core_mmio_lsu.sv
// core_mmio_lsu: MEM-stage uncached MMIO load/store unit with pipeline stall, byte-lane steering,
// alignment check and bus timeout
module core_mmio_lsu #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] MMIO_BASE = 64'h2000,
    parameter int              TIMEOUT   = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [2:0]           req_load_type,
    input  logic [2:0]           req_store_type,
    input  logic                 req_signed,
    input  logic                 flush,
    core_mmio_lsu_if.master      bus,
    output logic                 stall,
    output logic                 rsp_valid,
    output logic [XLEN-1:0]      rsp_data,
    output logic                 addr_err,
    output logic                 bus_err
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;
    state_t          state;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      size_q;
    logic            we_q;
    logic            sign_q;
    logic [15:0]     cnt;
    logic            is_store;
    logic [2:0]      req_size;
    logic            hit;
    logic            misaligned;
    logic            tmo;
    logic [7:0]      be_mask;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ext;
    assign is_store   = req_store_type != 3'd0;
    assign req_size   = is_store ? req_store_type : req_load_type;
    assign hit        = req_valid && req_size != 3'd0 && req_addr >= MMIO_BASE && !flush;
    assign misaligned = (req_size == 3'd2 && req_addr[0]) ||
                        (req_size == 3'd3 && |req_addr[1:0]) ||
                        (req_size >= 3'd4 && |req_addr[2:0]);
    assign tmo        = cnt >= 16'(TIMEOUT - 1);
    assign be_mask    = size_q == 3'd1 ? 8'h01 : size_q == 3'd2 ? 8'h03 : size_q == 3'd3 ? 8'h0F : 8'hFF;
    assign shifted    = bus.rdata >> {addr_q[2:0], 3'b000};
    always_comb begin
        ext = size_q == 3'd1 ? {{(XLEN-8){sign_q & shifted[7]}}, shifted[7:0]} :
              size_q == 3'd2 ? {{(XLEN-16){sign_q & shifted[15]}}, shifted[15:0]} :
              size_q == 3'd3 ? {{(XLEN-32){sign_q & shifted[31]}}, shifted[31:0]} : shifted;
    end
    // bus outputs are only driven while a request is outstanding
    assign bus.req_valid = state == REQ;
    assign bus.we        = state == REQ && we_q;
    assign bus.addr      = state == REQ ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign bus.wdata     = state == REQ ? wdata_q << {addr_q[2:0], 3'b000} : '0;
    assign bus.be        = state == REQ ? be_mask << addr_q[2:0] : 8'h00;
    assign stall     = (state == IDLE && hit && !misaligned) || state == REQ || state == WAIT || state == DRAIN;
    assign addr_err  = state == IDLE && hit && misaligned;
    assign rsp_valid = state == DONE;
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= 3'd0;
            we_q     <= 1'b0;
            sign_q   <= 1'b0;
            cnt      <= 16'd0;
            rsp_data <= '0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            if (state == REQ || state == WAIT || state == DRAIN) cnt <= cnt + 16'd1;
            case (state)
                IDLE: if (hit && !misaligned) begin
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    size_q  <= req_size;
                    we_q    <= is_store;
                    sign_q  <= req_signed;
                    cnt     <= 16'd0;
                    state   <= REQ;
                end
                // an accepted request is never withdrawn; a flushed load still owes a response
                REQ: if (bus.req_ready) state <= we_q ? (flush ? IDLE : DONE) : (flush ? DRAIN : WAIT);
                else if (flush) state <= IDLE;
                else if (tmo) begin
                    state    <= DONE;
                    bus_err  <= 1'b1;
                    rsp_data <= '0;
                end
                WAIT: if (bus.rsp_valid) begin
                    state <= flush ? IDLE : DONE;
                    if (!flush) rsp_data <= ext;
                end else if (flush) state <= DRAIN;
                else if (tmo) begin
                    state    <= DONE;
                    bus_err  <= 1'b1;
                    rsp_data <= '0;
                end
                DRAIN: if (bus.rsp_valid) state <= IDLE;
                else if (tmo) begin
                    state   <= IDLE;
                    bus_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
